// File: rtl/riscv_pkg.sv
// Shared pipeline-control types: interrupt FSM states,
// default flush-range limits and a flush-mask helper.
package riscv_pkg;

  typedef enum logic {
    IRQ_IDLE  = 1'b0,
    IRQ_DRAIN = 1'b1
  } irq_state_e;

  // Highest register index flushed by each cause
  localparam int unsigned REDIRECT_FLUSH_HI = 1;
  localparam int unsigned TRAP_FLUSH_HI     = 2;

  // Mask with bits 0..hi set
  function automatic logic [31:0] flush_range(
    input int unsigned hi
  );
    return (32'd2 << hi) - 32'd1;
  endfunction

endpackage

// File: rtl/lo_scoreboard.sv
// Long-latency op scoreboard: per-register busy bits plus
// outstanding counter; reports decode hazard, full, empty.
// Ports: clk_i/rst_i, issue_*/done_* updates,
//   rs_i/rd_i/writes_rd_i/is_long_i decode query,
//   hazard_o, full_o, cnt_zero_o.
module lo_scoreboard import riscv_pkg::*; #(
  parameter int NRS    = 2,
  parameter int MAXOUT = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_i,
  input  logic [4:0]          issue_rd_i,
  input  logic                done_i,
  input  logic [4:0]          done_rd_i,
  input  logic [NRS-1:0][4:0] rs_i,
  input  logic [4:0]          rd_i,
  input  logic                writes_rd_i,
  input  logic                is_long_i,
  output logic                hazard_o,
  output logic                full_o,
  output logic                cnt_zero_o
);

  localparam int CW = $clog2(MAXOUT + 1);

  logic [31:0]   r_busy;
  logic [CW-1:0] r_cnt;
  logic [31:0]   w_set;
  logic [31:0]   w_clr;
  logic          w_full;
  logic          w_raw;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_i && issue_rd_i != 5'd0)
      w_set[issue_rd_i] = 1'b1;
    if (done_i)
      w_clr[done_rd_i] = 1'b1;
  end

  // Set after clear: same-rd issue+done keeps the bit busy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      if (issue_i && !done_i && r_cnt != CW'(MAXOUT))
        r_cnt <= r_cnt + 1'b1;
      else if (done_i && !issue_i && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign w_full     = ~rst_i & (r_cnt == CW'(MAXOUT));
  assign full_o     = w_full;
  assign cnt_zero_o = (r_cnt == '0);

  always_comb begin
    w_raw = 1'b0;
    for (int i = 0; i < NRS; i++)
      if (rs_i[i] != 5'd0 && r_busy[rs_i[i]])
        w_raw = 1'b1;
  end

  assign hazard_o = w_raw
                  | (writes_rd_i & r_busy[rd_i])
                  | (is_long_i & w_full);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX operand forwarding, load-use
// and scoreboard stalls, flush/stall chaining, IRQ drain FSM.
// Ports: decode/execute operand info, forwarding bus, long-op
//   issue/done, redirect/trap, irq lines; stall_o/flush_o out.
module hazard_ctrl import riscv_pkg::*; #(
  parameter int NRS     = 2,
  parameter int NFWD    = 2,
  parameter int NSTG    = 4,
  parameter int EX_IDX  = REDIRECT_FLUSH_HI,
  parameter int MEM_IDX = TRAP_FLUSH_HI,
  parameter int NIRQ    = 3,
  parameter int MAXOUT  = 4,
  localparam int SW = $clog2(NFWD + 1),
  localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NRS-1:0][4:0]   rs_d_i,
  input  logic [4:0]            rd_d_i,
  input  logic                  d_writes_rd_i,
  input  logic                  d_is_long_i,
  input  logic [NRS-1:0][4:0]   rs_e_i,
  input  logic [4:0]            rd_e_i,
  input  logic                  e_writes_rd_i,
  input  logic                  e_late_result_i,
  input  logic [NFWD-1:0][4:0]  fwd_rd_i,
  input  logic [NFWD-1:0]       fwd_we_i,
  input  logic [NFWD-1:0][31:0] fwd_data_i,
  output logic [NRS-1:0][SW-1:0] fwd_sel_o,
  output logic [NRS-1:0][31:0]  fwd_data_o,
  input  logic                  lo_issue_i,
  input  logic [4:0]            lo_issue_rd_i,
  input  logic                  lo_done_i,
  input  logic [4:0]            lo_done_rd_i,
  output logic                  lo_full_o,
  input  logic                  redirect_i,
  input  logic                  trap_i,
  input  logic [NSTG-1:0]       stall_req_i,
  input  logic [NIRQ-1:0]       irq_pending_i,
  input  logic                  irq_en_i,
  input  logic [NSTG-2:0]       pipe_valid_i,
  input  logic [31:0]           if_pc_i,
  output logic                  take_irq_o,
  output logic [IW-1:0]         irq_idx_o,
  output logic [31:0]           irq_pc_o,
  output logic [NSTG-1:0]       stall_o,
  output logic [NSTG-1:0]       flush_o
);

  irq_state_e      r_state;
  irq_state_e      w_state_nxt;
  logic            w_take;
  logic            w_irq_cond;
  logic            w_load_use;
  logic            w_sb_haz;
  logic            w_cnt_zero;
  logic [31:0]     w_fc32;
  logic [NSTG-1:0] w_fcause;
  logic [NSTG-1:0] w_cause;
  logic [NSTG-1:0] w_stall;
  logic [NSTG-1:0] w_flush;
  logic [NSTG-1:0] w_tmp;

  // Descending scan so the youngest matching stage wins
  always_comb begin
    for (int i = 0; i < NRS; i++) begin
      fwd_sel_o[i]  = '0;
      fwd_data_o[i] = '0;
      if (rs_e_i[i] != 5'd0) begin
        for (int k = NFWD - 1; k >= 0; k--) begin
          if (fwd_we_i[k] && fwd_rd_i[k] == rs_e_i[i]) begin
            fwd_sel_o[i]  = SW'(k + 1);
            fwd_data_o[i] = fwd_data_i[k];
          end
        end
      end
    end
  end

  always_comb begin
    w_load_use = 1'b0;
    if (e_late_result_i && e_writes_rd_i && rd_e_i != 5'd0)
      for (int i = 0; i < NRS; i++)
        if (rs_d_i[i] == rd_e_i)
          w_load_use = 1'b1;
  end

  lo_scoreboard #(
    .NRS    (NRS),
    .MAXOUT (MAXOUT)
  ) u_sb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .issue_i     (lo_issue_i),
    .issue_rd_i  (lo_issue_rd_i),
    .done_i      (lo_done_i),
    .done_rd_i   (lo_done_rd_i),
    .rs_i        (rs_d_i),
    .rd_i        (rd_d_i),
    .writes_rd_i (d_writes_rd_i),
    .is_long_i   (d_is_long_i),
    .hazard_o    (w_sb_haz),
    .full_o      (lo_full_o),
    .cnt_zero_o  (w_cnt_zero)
  );

  assign w_irq_cond = irq_en_i & (|irq_pending_i);

  always_comb begin
    irq_idx_o = '0;
    for (int j = NIRQ - 1; j >= 0; j--)
      if (irq_pending_i[j])
        irq_idx_o = IW'(j);
  end

  assign irq_pc_o = if_pc_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IRQ_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    unique case (r_state)
      IRQ_IDLE: begin
        if (w_irq_cond) w_state_nxt = IRQ_DRAIN;
      end
      IRQ_DRAIN: begin
        if (!w_irq_cond || trap_i) begin
          w_state_nxt = IRQ_IDLE;
        end else if (pipe_valid_i == '0 && w_cnt_zero) begin
          w_take      = 1'b1;
          w_state_nxt = IRQ_IDLE;
        end
      end
      default: w_state_nxt = IRQ_IDLE;
    endcase
  end

  // Reset in DRAIN must not leak a pulse before the edge
  assign take_irq_o = w_take & ~rst_i;

  always_comb begin
    w_fc32 = '0;
    if (redirect_i) w_fc32 = w_fc32 | flush_range(EX_IDX);
    if (trap_i)     w_fc32 = w_fc32 | flush_range(MEM_IDX);
    if (take_irq_o) w_fc32 = '1;
    w_fcause = w_fc32[NSTG-1:0];

    w_cause    = stall_req_i;
    w_cause[0] = w_cause[0] | w_load_use | w_sb_haz
               | (r_state == IRQ_DRAIN);
    w_cause    = w_cause & ~w_fcause;

    // A register stalls if it or any older one stalls
    for (int k = 0; k < NSTG; k++) begin
      w_tmp      = w_cause >> k;
      w_stall[k] = |w_tmp;
    end

    // Bubble into a register whose upstream neighbour holds
    w_flush[0] = w_fcause[0];
    for (int k = 1; k < NSTG; k++)
      w_flush[k] = w_fcause[k] | (w_stall[k-1] & ~w_stall[k]);
  end

  assign stall_o = rst_i ? '0 : w_stall;
  assign flush_o = rst_i ? '1 : w_flush;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
// One task per feature; inline comparisons.
module tb_hazard_ctrl;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [1:0][4:0]  rs_d_i;
  logic [4:0]       rd_d_i;
  logic             d_writes_rd_i;
  logic             d_is_long_i;
  logic [1:0][4:0]  rs_e_i;
  logic [4:0]       rd_e_i;
  logic             e_writes_rd_i;
  logic             e_late_result_i;
  logic [1:0][4:0]  fwd_rd_i;
  logic [1:0]       fwd_we_i;
  logic [1:0][31:0] fwd_data_i;
  logic [1:0][1:0]  fwd_sel_o;
  logic [1:0][31:0] fwd_data_o;
  logic             lo_issue_i;
  logic [4:0]       lo_issue_rd_i;
  logic             lo_done_i;
  logic [4:0]       lo_done_rd_i;
  logic             lo_full_o;
  logic             redirect_i;
  logic             trap_i;
  logic [3:0]       stall_req_i;
  logic [2:0]       irq_pending_i;
  logic             irq_en_i;
  logic [2:0]       pipe_valid_i;
  logic [31:0]      if_pc_i;
  logic             take_irq_o;
  logic [1:0]       irq_idx_o;
  logic [31:0]      irq_pc_o;
  logic [3:0]       stall_o;
  logic [3:0]       flush_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .rs_d_i          (rs_d_i),
    .rd_d_i          (rd_d_i),
    .d_writes_rd_i   (d_writes_rd_i),
    .d_is_long_i     (d_is_long_i),
    .rs_e_i          (rs_e_i),
    .rd_e_i          (rd_e_i),
    .e_writes_rd_i   (e_writes_rd_i),
    .e_late_result_i (e_late_result_i),
    .fwd_rd_i        (fwd_rd_i),
    .fwd_we_i        (fwd_we_i),
    .fwd_data_i      (fwd_data_i),
    .fwd_sel_o       (fwd_sel_o),
    .fwd_data_o      (fwd_data_o),
    .lo_issue_i      (lo_issue_i),
    .lo_issue_rd_i   (lo_issue_rd_i),
    .lo_done_i       (lo_done_i),
    .lo_done_rd_i    (lo_done_rd_i),
    .lo_full_o       (lo_full_o),
    .redirect_i      (redirect_i),
    .trap_i          (trap_i),
    .stall_req_i     (stall_req_i),
    .irq_pending_i   (irq_pending_i),
    .irq_en_i        (irq_en_i),
    .pipe_valid_i    (pipe_valid_i),
    .if_pc_i         (if_pc_i),
    .take_irq_o      (take_irq_o),
    .irq_idx_o       (irq_idx_o),
    .irq_pc_o        (irq_pc_o),
    .stall_o         (stall_o),
    .flush_o         (flush_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    rs_d_i = '0; rd_d_i = '0;
    d_writes_rd_i = 0; d_is_long_i = 0;
    rs_e_i = '0; rd_e_i = '0;
    e_writes_rd_i = 0; e_late_result_i = 0;
    fwd_rd_i = '0; fwd_we_i = '0; fwd_data_i = '0;
    lo_issue_i = 0; lo_issue_rd_i = '0;
    lo_done_i = 0; lo_done_rd_i = '0;
    redirect_i = 0; trap_i = 0; stall_req_i = '0;
    irq_pending_i = '0; irq_en_i = 0;
    pipe_valid_i = '0; if_pc_i = 32'h0000_1000;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_i = 1;
    step(); step();
    checks++;
    if (stall_o !== 4'b0000) begin
      failures++;
      $display("FAIL rst_stall got=%b exp=0000", stall_o);
    end
    checks++;
    if (flush_o !== 4'b1111) begin
      failures++;
      $display("FAIL rst_flush got=%b exp=1111", flush_o);
    end
    checks++;
    if (take_irq_o !== 1'b0 || lo_full_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_take_full got=%b%b exp=00",
               take_irq_o, lo_full_o);
    end
    rst_i = 0;
    step();
    checks++;
    if (stall_o !== 4'b0000 || flush_o !== 4'b0000) begin
      failures++;
      $display("FAIL idle_ctrl got=%b/%b exp=0000/0000",
               stall_o, flush_o);
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    fwd_rd_i[0] = 5'd5; fwd_rd_i[1] = 5'd5;
    fwd_we_i = 2'b11;
    fwd_data_i[0] = 32'hAAAA_0000;
    fwd_data_i[1] = 32'hBBBB_1111;
    rs_e_i[0] = 5'd5; rs_e_i[1] = 5'd0;
    #1;
    checks++;
    if (fwd_sel_o[0] !== 2'd1 || fwd_sel_o[1] !== 2'd0) begin
      failures++;
      $display("FAIL fwd_sel got=%0d,%0d exp=1,0",
               fwd_sel_o[0], fwd_sel_o[1]);
    end
    checks++;
    if (fwd_data_o[0] !== 32'hAAAA_0000 ||
        fwd_data_o[1] !== 32'h0) begin
      failures++;
      $display("FAIL fwd_data got=%h,%h exp=aaaa0000,0",
               fwd_data_o[0], fwd_data_o[1]);
    end
    fwd_we_i = 2'b10;
    fwd_rd_i[0] = 5'd0;
    rs_e_i[1] = 5'd6;
    #1;
    checks++;
    if (fwd_sel_o[0] !== 2'd2 ||
        fwd_data_o[0] !== 32'hBBBB_1111 ||
        fwd_sel_o[1] !== 2'd0) begin
      failures++;
      $display("FAIL fwd_old got=%0d/%h/%0d exp=2/bbbb1111/0",
               fwd_sel_o[0], fwd_data_o[0], fwd_sel_o[1]);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    e_late_result_i = 1; e_writes_rd_i = 1; rd_e_i = 5'd7;
    rs_d_i[1] = 5'd7;
    #1;
    checks++;
    if (stall_o !== 4'b0001 || flush_o !== 4'b0010) begin
      failures++;
      $display("FAIL load_use got=%b/%b exp=0001/0010",
               stall_o, flush_o);
    end
    step();
    e_late_result_i = 0;
    #1;
    checks++;
    if (stall_o !== 4'b0000 || flush_o !== 4'b0000) begin
      failures++;
      $display("FAIL lu_release got=%b/%b exp=0000/0000",
               stall_o, flush_o);
    end
    e_late_result_i = 1; rd_e_i = 5'd0; rs_d_i[1] = 5'd0;
    #1;
    checks++;
    if (stall_o !== 4'b0000) begin
      failures++;
      $display("FAIL lu_x0 got=%b exp=0000", stall_o);
    end
  endtask

  task automatic test_scoreboard();
    clear_inputs();
    lo_issue_i = 1; lo_issue_rd_i = 5'd9;
    step();
    lo_issue_i = 0;
    rs_d_i[0] = 5'd9;
    #1;
    checks++;
    if (stall_o !== 4'b0001) begin
      failures++;
      $display("FAIL sb_raw got=%b exp=0001", stall_o);
    end
    step();
    lo_done_i = 1; lo_done_rd_i = 5'd9;
    #1;
    checks++;
    if (stall_o !== 4'b0001) begin
      failures++;
      $display("FAIL sb_done_cyc got=%b exp=0001", stall_o);
    end
    step();
    lo_done_i = 0;
    #1;
    checks++;
    if (stall_o !== 4'b0000) begin
      failures++;
      $display("FAIL sb_after_done got=%b exp=0000", stall_o);
    end
    rs_d_i[0] = 5'd0;
    lo_issue_i = 1; lo_issue_rd_i = 5'd9;
    step();
    lo_issue_i = 0;
    d_writes_rd_i = 1; rd_d_i = 5'd9;
    #1;
    checks++;
    if (stall_o !== 4'b0001) begin
      failures++;
      $display("FAIL sb_waw got=%b exp=0001", stall_o);
    end
    lo_done_i = 1; lo_done_rd_i = 5'd9;
    step();
    lo_done_i = 0; d_writes_rd_i = 0; rd_d_i = 5'd0;
    lo_issue_i = 1; lo_issue_rd_i = 5'd10;
    step();
    lo_done_i = 1; lo_done_rd_i = 5'd10;
    step();
    lo_issue_i = 0; lo_done_i = 0;
    rs_d_i[1] = 5'd10;
    #1;
    checks++;
    if (stall_o !== 4'b0001) begin
      failures++;
      $display("FAIL sb_same_rd got=%b exp=0001", stall_o);
    end
    lo_done_i = 1; lo_done_rd_i = 5'd10;
    step();
    lo_done_i = 0; rs_d_i[1] = 5'd0;
    for (int n = 1; n <= 4; n++) begin
      lo_issue_i = 1; lo_issue_rd_i = 5'(n);
      step();
      if (n == 3) begin
        checks++;
        if (lo_full_o !== 1'b0) begin
          failures++;
          $display("FAIL sb_3out got=%b exp=0", lo_full_o);
        end
      end
    end
    lo_issue_i = 0;
    d_is_long_i = 1;
    #1;
    checks++;
    if (lo_full_o !== 1'b1 || stall_o !== 4'b0001) begin
      failures++;
      $display("FAIL sb_full got=%b/%b exp=1/0001",
               lo_full_o, stall_o);
    end
    lo_done_i = 1; lo_done_rd_i = 5'd1;
    step();
    lo_done_i = 0;
    #1;
    checks++;
    if (lo_full_o !== 1'b0 || stall_o !== 4'b0000) begin
      failures++;
      $display("FAIL sb_unfull got=%b/%b exp=0/0000",
               lo_full_o, stall_o);
    end
    d_is_long_i = 0;
    for (int n = 2; n <= 4; n++) begin
      lo_done_i = 1; lo_done_rd_i = 5'(n);
      step();
    end
    lo_done_i = 0;
  endtask

  task automatic test_irq_take();
    clear_inputs();
    if_pc_i = 32'h8000_0040;
    irq_en_i = 1; irq_pending_i = 3'b110;
    pipe_valid_i = 3'b011;
    #1;
    checks++;
    if (take_irq_o !== 1'b0 || stall_o !== 4'b0000) begin
      failures++;
      $display("FAIL irq_idle got=%b/%b exp=0/0000",
               take_irq_o, stall_o);
    end
    step();
    checks++;
    if (take_irq_o !== 1'b0 || stall_o !== 4'b0001) begin
      failures++;
      $display("FAIL irq_drain1 got=%b/%b exp=0/0001",
               take_irq_o, stall_o);
    end
    pipe_valid_i = 3'b010;
    step();
    checks++;
    if (take_irq_o !== 1'b0 || stall_o !== 4'b0001) begin
      failures++;
      $display("FAIL irq_drain2 got=%b/%b exp=0/0001",
               take_irq_o, stall_o);
    end
    pipe_valid_i = 3'b000;
    #1;
    checks++;
    if (take_irq_o !== 1'b1 || irq_idx_o !== 2'd1 ||
        irq_pc_o !== 32'h8000_0040) begin
      failures++;
      $display("FAIL irq_take got=%b/%0d/%h exp=1/1/80000040",
               take_irq_o, irq_idx_o, irq_pc_o);
    end
    checks++;
    if (flush_o !== 4'b1111 || stall_o !== 4'b0000) begin
      failures++;
      $display("FAIL irq_flush got=%b/%b exp=1111/0000",
               flush_o, stall_o);
    end
    step();
    irq_pending_i = '0;
    #1;
    checks++;
    if (take_irq_o !== 1'b0) begin
      failures++;
      $display("FAIL irq_one_pulse got=%b exp=0", take_irq_o);
    end
  endtask

  task automatic test_trap_drain();
    clear_inputs();
    irq_en_i = 1; irq_pending_i = 3'b001;
    pipe_valid_i = 3'b001;
    step();
    trap_i = 1;
    #1;
    checks++;
    if (flush_o !== 4'b0111 || take_irq_o !== 1'b0 ||
        stall_o !== 4'b0000) begin
      failures++;
      $display("FAIL trap_drain got=%b/%b/%b exp=0111/0/0000",
               flush_o, take_irq_o, stall_o);
    end
    step();
    trap_i = 0; pipe_valid_i = 3'b000;
    #1;
    checks++;
    if (take_irq_o !== 1'b0 || stall_o !== 4'b0000) begin
      failures++;
      $display("FAIL trap_idle got=%b/%b exp=0/0000",
               take_irq_o, stall_o);
    end
    irq_pending_i = '0;
    step();
  endtask

  task automatic test_irq_reset();
    clear_inputs();
    irq_en_i = 1; irq_pending_i = 3'b001;
    pipe_valid_i = 3'b001;
    step();
    pipe_valid_i = 3'b000;
    rst_i = 1;
    #1;
    checks++;
    if (take_irq_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_drain got=%b exp=0", take_irq_o);
    end
    step();
    rst_i = 0;
    #1;
    checks++;
    if (take_irq_o !== 1'b0 || stall_o !== 4'b0000) begin
      failures++;
      $display("FAIL rst_abandon got=%b/%b exp=0/0000",
               take_irq_o, stall_o);
    end
    irq_pending_i = '0;
    step();
  endtask

  task automatic test_redirect_stall();
    clear_inputs();
    redirect_i = 1;
    #1;
    checks++;
    if (flush_o !== 4'b0011 || stall_o !== 4'b0000) begin
      failures++;
      $display("FAIL redirect got=%b/%b exp=0011/0000",
               flush_o, stall_o);
    end
    stall_req_i = 4'b0100;
    #1;
    checks++;
    if (stall_o !== 4'b0111 || flush_o !== 4'b1011) begin
      failures++;
      $display("FAIL redir_req2 got=%b/%b exp=0111/1011",
               stall_o, flush_o);
    end
    redirect_i = 0;
    stall_req_i = 4'b1000;
    #1;
    checks++;
    if (stall_o !== 4'b1111 || flush_o !== 4'b0000) begin
      failures++;
      $display("FAIL req3_chain got=%b/%b exp=1111/0000",
               stall_o, flush_o);
    end
    stall_req_i = 4'b0010;
    trap_i = 1;
    #1;
    checks++;
    if (stall_o !== 4'b0000 || flush_o !== 4'b0111) begin
      failures++;
      $display("FAIL trap_supp got=%b/%b exp=0000/0111",
               stall_o, flush_o);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_scoreboard();
    test_irq_take();
    test_trap_drain();
    test_irq_reset();
    test_redirect_stall();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameters: NRS, default 2, source operands per instruction; NFWD, default 2, forwarding producer stages (index 0 = youngest); NSTG, default 4, pipeline registers (0 = IF/ID); EX_IDX, default 1, index of the ID/EX register; MEM_IDX, default 2, index of the EX/MEM register; NIRQ, default 3, interrupt lines (index 0 = highest priority); MAXOUT, default 4, maximum outstanding long-latency operations.
REQ-002 SHALL have one clock; reset is synchronous and active-high: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-003 SHALL have these decode-stage inputs: rs_d_i  in  NRSx5  ID sources; rd_d_i  in  5  ID destination; d_writes_rd_i  in  1; d_is_long_i  in  1  ID instruction is a long-latency op.
REQ-004 SHALL have these execute-stage inputs: rs_e_i  in  NRSx5; rd_e_i  in  5; e_writes_rd_i  in  1; e_late_result_i  in  1  EX result is unavailable until MEM (load or CSR read).
REQ-005 SHALL have these forwarding ports: fwd_rd_i  in  NFWDx5; fwd_we_i  in  NFWD; fwd_data_i  in  NFWDx32; fwd_sel_o  out  NRSx$clog2(NFWD+1)  0 = no forward, k = stage k-1; fwd_data_o  out  NRSx32.
REQ-006 SHALL have these long-op ports: lo_issue_i  in  1; lo_issue_rd_i  in  5; lo_done_i  in  1; lo_done_rd_i  in  5; lo_full_o  out  1.
REQ-007 SHALL have these control inputs: redirect_i  in  1  branch/jump taken in EX; trap_i  in  1  trap/MRET/CSR write in MEM; stall_req_i  in  NSTG  per-register external stall causes.
REQ-008 SHALL have these interrupt ports: irq_pending_i  in  NIRQ; irq_en_i  in  1; pipe_valid_i  in  NSTG-1  valid bits of registers 1..NSTG-1; if_pc_i  in  32; take_irq_o  out  1; irq_idx_o  out  $clog2(NIRQ); irq_pc_o  out  32.
REQ-009 SHALL have these pipeline control outputs: stall_o  out  NSTG; flush_o  out  NSTG.

Function
REQ-010 Forwarding (combinational): for each operand i with rs_e_i[i]!=0, fwd_sel_o[i] SHALL select the lowest k with fwd_we_i[k] and fwd_rd_i[k]==rs_e_i[i]; otherwise 0; fwd_data_o[i]=fwd_data_i[k], else 0.
REQ-011 Load-use hazard SHALL be asserted when e_late_result_i and e_writes_rd_i and rd_e_i!=0 and any rs_d_i equals rd_e_i.
REQ-012 Scoreboard: 32 busy bits; lo_issue_i with lo_issue_rd_i!=0 SHALL set busy[rd] at the next edge; lo_done_i SHALL clear busy[lo_done_rd_i]; when issue and done target the same rd in one cycle, busy SHALL remain set.
REQ-013 Outstanding counter 0..MAXOUT: +1 on issue, -1 on done, unchanged on both; lo_full_o = (count==MAXOUT).
REQ-014 Scoreboard hazard SHALL be asserted when any nonzero rs_d_i is busy, when d_writes_rd_i and rd_d_i is busy (WAW), or when d_is_long_i and lo_full_o.
REQ-015 IRQ FSM states: IDLE, DRAIN. IDLE->DRAIN when irq_en_i and |irq_pending_i. In DRAIN: go to IDLE without taking when the interrupt condition drops or trap_i is high; otherwise when pipe_valid_i==0 and count==0, assert take_irq_o for one cycle and go to IDLE.
REQ-016 irq_idx_o SHALL be the lowest set index of irq_pending_i; irq_pc_o = if_pc_i; both are valid only with take_irq_o.
REQ-017 Flush causes: redirect_i flushes registers 0..EX_IDX; trap_i flushes 0..MEM_IDX; take_irq_o flushes 0..NSTG-1.
REQ-018 Stall causes: register 0 stalls on the load-use hazard, the scoreboard hazard, or state DRAIN; register k also stalls on stall_req_i[k]; a register's stall cause SHALL be suppressed when a flush cause hits that register.
REQ-019 stall_o[k] = cause[k] | stall_o[k+1] for k<NSTG-1.
REQ-020 flush_o[k] = flushcause[k] | (stall_o[k-1] & ~stall_o[k]) for k>=1; flush_o[0] = flushcause[0].

Reset
REQ-021 While rst_i is high: state=IDLE, busy=0, count=0, stall_o=0, flush_o=all ones, take_irq_o=0, lo_full_o=0.
REQ-022 Reset asserted mid-DRAIN SHALL abandon the interrupt with no take_irq_o pulse.

Structure
REQ-023 The FSM state enum and the flush-range constants SHALL be placed in the shared riscv_pkg.
REQ-024 The scoreboard (busy bits plus counter) SHALL be a sub-module named lo_scoreboard.

Verification
REQ-025 x5 in fwd stages 0 and 1 with rs_e={5,0} -> fwd_sel_o={1,0}, data from stage 0.
REQ-026 Load to x7 in EX, ID reads x7 -> stall_o=0001, flush_o[1]=1 for one cycle.
REQ-027 Long op issued to x9, ID reads x9 -> stalled until the cycle after lo_done_i(x9); with MAXOUT=4 issues, a 5th long op stalls while lo_full_o=1.
REQ-028 irq_pending=3'b110 with 2 valid stages -> DRAIN for 2 cycles, then take_irq_o pulse with irq_idx_o=1 and flush_o all ones.
REQ-029 trap_i during DRAIN -> IDLE, no take_irq_o, flush_o=0111.
